// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - md_op encodings (MD_MULT .. MD_MSUBU)
//   - default latencies for multiply and divide
//   - 64-bit {hi,lo} result type and the FSM state type
//   - ext64(): zero- or sign-extends a 32-bit operand to 64 bits
package mdu_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  // Wide enough for any sensible latency setting.
  localparam int CNT_W = 8;

  // {hi, lo}
  typedef logic [63:0] md_res_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  function automatic md_res_t ext64(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: combinational 32-bit divider, signed or unsigned.
//   Quotient truncates toward zero; remainder takes the sign of the dividend.
//   Handles 0x80000000 / -1 explicitly (quotient 0x80000000, remainder 0).
// Ports:
//   dividend  in  32  rs operand
//   divisor   in  32  rt operand
//   is_signed in   1  1 = DIV, 0 = DIVU
//   res       out 64  {remainder, quotient}; zero when divisor is zero
//   div_zero  out  1  divisor is zero; caller must not commit res
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output md_res_t     res,
  output logic        div_zero
);

  logic        neg_q;
  logic        neg_r;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    neg_r    = is_signed & dividend[31];
    neg_q    = is_signed & (dividend[31] ^ divisor[31]);
    // Magnitude of 0x80000000 is 0x80000000 when viewed unsigned, which is correct.
    mag_a    = neg_r ? -dividend : dividend;
    mag_b    = (is_signed & divisor[31]) ? -divisor : divisor;
    div_zero = (divisor == 32'd0);
    uq       = 32'd0;
    ur       = 32'd0;
    if (!div_zero) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quot = neg_q ? -uq : uq;
    rem  = neg_r ? -ur : ur;
    if (is_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end
    res = {rem, quot};
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multiply/divide unit owning the architectural HI/LO.
//   mult/multu/div/divu compute their result at the start edge into a pending
//   register, then commit it to hi/lo after a fixed latency while busy is high.
//   mthi/mtlo write immediately. Any start while busy is ignored.
//   Optional MDU_MADD_EN adds madd/maddu/msub/msubu (ops 6-9), accumulating
//   onto the hi/lo values present at the start edge; without it ops 6-9 are no-ops.
// Ports:
//   clk     in   1  pipeline clock, rising edge
//   reset   in   1  synchronous, active-high
//   start   in   1  one-cycle issue pulse
//   md_op   in   4  operation select (see mdu_pkg)
//   rs_val  in  32  rs operand
//   rt_val  in  32  rt operand
//   busy    out  1  operation in flight
//   hi      out 32  architectural HI
//   lo      out 32  architectural LO
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting start; mthi/mtlo complete here
// ST_RUN  | counting down; pending result commits when counter == 1
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  md_state_t        state;
  logic [CNT_W-1:0] counter;
  md_res_t          res;
  logic             res_wr;

  logic    mul_signed;
  md_res_t prod;
  md_res_t div_res;
  logic    div_zero;

  always_comb begin
`ifdef MDU_MADD_EN
    mul_signed = (md_op == MD_MULT) || (md_op == MD_MADD) || (md_op == MD_MSUB);
`else
    mul_signed = (md_op == MD_MULT);
`endif
    // Low 64 bits of the extended product are exact for both signednesses.
    prod = ext64(rs_val, mul_signed) * ext64(rt_val, mul_signed);
  end

`ifdef MDU_MADD_EN
  md_res_t acc_res;
  always_comb begin
    if ((md_op == MD_MSUB) || (md_op == MD_MSUBU)) acc_res = {hi, lo} - prod;
    else                                           acc_res = {hi, lo} + prod;
  end
`endif

  mdu_div_core u_div (
    .dividend (rs_val),
    .divisor  (rt_val),
    .is_signed(md_op == MD_DIV),
    .res      (div_res),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      res     <= '0;
      res_wr  <= 1'b0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                res     <= prod;
                res_wr  <= 1'b1;
                counter <= MUL_LOAD;
                busy    <= 1'b1;
                state   <= ST_RUN;
              end
              MD_DIV, MD_DIVU: begin
                res     <= div_res;
                // Divide by zero still occupies the unit but leaves hi/lo alone.
                res_wr  <= !div_zero;
                counter <= DIV_LOAD;
                busy    <= 1'b1;
                state   <= ST_RUN;
              end
              MD_MTHI: hi <= rs_val;
              MD_MTLO: lo <= rs_val;
`ifdef MDU_MADD_EN
              MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                res     <= acc_res;
                res_wr  <= 1'b1;
                counter <= MUL_LOAD;
                busy    <= 1'b1;
                state   <= ST_RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (counter == CNT_W'(1)) begin
            if (res_wr) begin
              hi <= res[63:32];
              lo <= res[31:0];
            end
            res_wr  <= 1'b0;
            counter <= '0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and random checks of mdu_unit against an
// arithmetic reference model of HI/LO.
module tb_mdu_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total  = 0;
  int passed = 0;

  logic [31:0] mhi;
  logic [31:0] mlo;

  mdu_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Applies one operation to the model HI/LO; returns busy latency (0 = immediate or no-op).
  function automatic int model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]     p;
    logic [63:0]     acc;
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    int              ia;
    int              ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd0: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; return MUL_N; end
      4'd1: begin p = ua * ub; mhi = p[63:32]; mlo = p[31:0]; return MUL_N; end
      4'd2: begin
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            mlo = 32'h8000_0000;
            mhi = 32'd0;
          end else begin
            ia  = $signed(a);
            ib  = $signed(b);
            mlo = ia / ib;
            mhi = ia % ib;
          end
        end
        return DIV_N;
      end
      4'd3: begin
        if (b != 32'd0) begin
          mlo = a / b;
          mhi = a % b;
        end
        return DIV_N;
      end
      4'd4: begin mhi = a; return 0; end
      4'd5: begin mlo = a; return 0; end
`ifdef MDU_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: begin
        if (op == 4'd6 || op == 4'd8) p = sa * sb;
        else                          p = ua * ub;
        acc = {mhi, mlo};
        acc = (op >= 4'd8) ? acc - p : acc + p;
        mhi = acc[63:32];
        mlo = acc[31:0];
        return MUL_N;
      end
`endif
      default: return 0;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] oh;
    logic [31:0] ol;
    int          lat;
    oh  = mhi;
    ol  = mlo;
    lat = model(op, a, b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    // Scramble operands so a design that fails to latch them is exposed.
    rs_val = $urandom;
    rt_val = $urandom;
    if (lat == 0) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " hi"}, hi, mhi);
      chk({tag, " lo"}, lo, mlo);
    end else begin
      chk({tag, " busy0"}, {31'd0, busy}, 32'd1);
      chk({tag, " old_hi"}, hi, oh);
      chk({tag, " old_lo"}, lo, ol);
      for (int k = 1; k < lat; k++) begin
        @(posedge clk);
        #1;
        chk({tag, " busy_run"}, {31'd0, busy}, 32'd1);
      end
      @(posedge clk);
      #1;
      chk({tag, " busy_done"}, {31'd0, busy}, 32'd0);
      chk({tag, " hi"}, hi, mhi);
      chk({tag, " lo"}, lo, mlo);
    end
  endtask

  initial begin
    logic [31:0] oh;
    logic [31:0] ol;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int          lat;
    int          sel;

    reset  = 1'b1;
    start  = 1'b0;
    md_op  = 4'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    mhi    = 32'd0;
    mlo    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    run_op("mult_neg", 4'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg hi_k", hi, 32'hFFFF_FFFF);
    chk("mult_neg lo_k", lo, 32'hFFFF_FFFA);

    run_op("multu_max", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max hi_k", hi, 32'hFFFF_FFFE);
    chk("multu_max lo_k", lo, 32'h0000_0001);

    run_op("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg hi_k", hi, 32'hFFFF_FFFF);
    chk("div_neg lo_k", lo, 32'hFFFF_FFFD);

    run_op("divu_zero", 4'd3, 32'd7, 32'd0);
    chk("divu_zero hi_k", hi, 32'hFFFF_FFFF);
    chk("divu_zero lo_k", lo, 32'hFFFF_FFFD);

    run_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf hi_k", hi, 32'd0);
    chk("div_ovf lo_k", lo, 32'h8000_0000);

    run_op("mthi", 4'd4, 32'h1234_5678, 32'd0);
    chk("mthi hi_k", hi, 32'h1234_5678);

    // MTLO issued while a DIVU is running must be dropped.
    oh  = mhi;
    ol  = mlo;
    lat = model(4'd3, 32'd100, 32'd7);
    start  = 1'b1;
    md_op  = 4'd3;
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start  = 1'b1;
    md_op  = 4'd5;
    rs_val = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mtlo_busy busy", {31'd0, busy}, 32'd1);
    chk("mtlo_busy lo_old", lo, ol);
    chk("mtlo_busy hi_old", hi, oh);
    repeat (lat - 3) @(posedge clk);
    #1;
    chk("mtlo_busy busy_last", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("mtlo_busy busy_done", {31'd0, busy}, 32'd0);
    chk("mtlo_busy lo", lo, 32'd14);
    chk("mtlo_busy hi", hi, 32'd2);

    // Reset in the middle of a DIV discards it.
    start  = 1'b1;
    md_op  = 4'd2;
    rs_val = 32'd1000;
    rt_val = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mhi   = 32'd0;
    mlo   = 32'd0;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    repeat (DIV_N + 2) @(posedge clk);
    #1;
    chk("midreset late_hi", hi, 32'd0);
    chk("midreset late_lo", lo, 32'd0);
    chk("midreset late_busy", {31'd0, busy}, 32'd0);

    run_op("pre_hi", 4'd4, 32'd0, 32'd0);
    run_op("pre_lo", 4'd5, 32'hFFFF_FFFF, 32'd0);
    run_op("op7", 4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    chk("maddu hi_k", hi, 32'd1);
    chk("maddu lo_k", lo, 32'd0);
`else
    chk("op7 noop hi_k", hi, 32'd0);
    chk("op7 noop lo_k", lo, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) b = -32'($urandom_range(1, 15));
      run_op("rand", op, a, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, next to the ALU.
- Owns the architectural HI/LO registers.
- Executes mult/multu/div/divu with fixed multi-cycle latency, handles mthi/mtlo, and exposes HI/LO for mfhi/mflo.
- Raises busy so the hazard unit can stall later MDU instructions.

Parameters:
- MUL_CYCLES, 5, cycles busy stays high for mult/multu.
- DIV_CYCLES, 10, cycles busy stays high for div/divu.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse from EX: issue the op in md_op.
- md_op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-9 reserved for the optional feature; others are no-ops.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- busy  output  1  an operation is in flight.
- hi  output  32  current HI.
- lo  output  32  current LO.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts the op and discards its result.
- States:
  - IDLE -> (start & mult/div op) -> RUN.
  - RUN -> (counter==1) -> IDLE.
- Start of mult/div:
  - At the start edge, latch the operands and compute the result into internal res_hi/res_lo.
  - Load counter with MUL_CYCLES or DIV_CYCLES.
  - busy=1 from the cycle after start.
  - Counter decrements each cycle in RUN.
  - On the edge where counter==1: copy res_hi/res_lo into hi/lo; busy drops the same edge.
  - Result visible on hi/lo exactly N cycles after the start edge (N = MUL_CYCLES or DIV_CYCLES).
- MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned product.
- DIV/DIVU:
  - lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend (rs_val).
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor zero: busy cycles normally; hi/lo unchanged at completion.
- MTHI/MTLO: with busy=0, write rs_val to hi or lo at the start edge. Busy never asserts.
- start while busy=1 is ignored; no state change. The hazard unit must stall instead, using start|busy to stall any MDU instruction in D.
- mfhi/mflo read hi/lo combinationally. During RUN they show the old values.
- Simultaneous final edge and new start: cannot occur, because busy=1 on that cycle, so the start is ignored.
- Reserved md_op with start: no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds op 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU.
  - {hi,lo} ± product, signed or unsigned per op, modulo 2^64.
  - Accumulation uses the hi/lo values at the start edge.
  - Latency MUL_CYCLES.
- Undefined: ops 6-9 are treated as reserved (no-op), and there is no accumulate datapath.

Decomposition:
- Shared package mdu_pkg: md_op encoding constants (MD_MULT…MD_MSUBU), MUL_CYCLES/DIV_CYCLES defaults, 64-bit result type.
- One sub-module, mdu_div_core: combinational signed/unsigned quotient/remainder with the zero and overflow special cases, so it can be unit-tested alone.
- Control, counter and HI/LO registers stay in mdu_unit.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high cycles 1-5; after edge 5: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles: hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> hi/lo unchanged, busy still 10 cycles.
- MTHI rs=0x12345678 with busy=0 -> hi=0x12345678 the next cycle, busy stays 0. MTLO issued while busy -> ignored, lo unchanged.
- Reset asserted at cycle 3 of a DIV -> next edge: busy=0, hi=lo=0. No later write occurs.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1×1 -> hi=1, lo=0. Without the macro: op 7 -> no change.
